// File: rtl/piso_tx_ctrl_pkg.sv
// Shared types for the PISO transmitter: controller state encoding.
package piso_tx_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_bit_cell.sv
// One PISO stage: a flop fed by a 2:1 mux selecting the parallel load bit
// (i_sel = 0) or the neighbouring stage's bit (i_sel = 1), with a hold enable.
module piso_bit_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sel,
  input  logic i_load_bit,
  input  logic i_shift_bit,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= i_sel ? i_shift_bit : i_load_bit;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmitter: word handshake in, one bit per accepted
// beat out, with zero-bubble reload when the next word is waiting.
module piso_tx_ctrl
  import piso_tx_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic             o_sout,
  output logic             o_sout_valid,
  input  logic             i_sout_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_done;
  logic            w_load;
  logic            w_take;
  logic            w_last;
  logic            w_din_ready;
  logic            w_sout_valid;
  logic            w_en;
  logic            w_sel;
  logic [WIDTH-1:0] w_shreg;
  logic [WIDTH-1:0] w_shift_in;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_last;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_take       = 1'b0;
    w_last       = 1'b0;
    w_din_ready  = 1'b0;
    w_sout_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_din_ready = 1'b1;
        if (i_din_valid) begin
          w_load      = 1'b1;
          w_cnt_nxt   = CNT_LAST;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_sout_valid = 1'b1;
        if (i_sout_ready) begin
          w_take = 1'b1;
          if (r_cnt == '0) begin
            w_last      = 1'b1;
            w_din_ready = 1'b1;
            if (i_din_valid) begin
              w_load    = 1'b1;
              w_cnt_nxt = CNT_LAST;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The final bit is shifted out too, so the register reads all-zero in IDLE.
  assign w_en  = w_load | w_take;
  assign w_sel = ~w_load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_end
        assign w_shift_in[i] = 1'b0;
      end else begin : g_mid
        assign w_shift_in[i] = w_shreg[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_end
        assign w_shift_in[i] = 1'b0;
      end else begin : g_mid
        assign w_shift_in[i] = w_shreg[i+1];
      end
    end

    piso_bit_cell u_cell (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (w_en),
      .i_sel       (w_sel),
      .i_load_bit  (i_din[i]),
      .i_shift_bit (w_shift_in[i]),
      .o_q         (w_shreg[i])
    );
  end

  assign o_sout       = MSB_FIRST ? w_shreg[WIDTH-1] : w_shreg[0];
  assign o_sout_valid = w_sout_valid;
  assign o_din_ready  = w_din_ready;
  assign o_busy       = (r_state == ST_SHIFT);
  assign o_done       = r_done;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl: an MSB-first and an LSB-first instance
// driven with directed words; monitors pop expected bits and done cycles.
module tb_piso_tx_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] din [2];
  logic       dinValid [2];
  logic       dinReady [2];
  logic       sout [2];
  logic       soutValid [2];
  logic       soutReady [2];
  logic       busy [2];
  logic       done [2];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic bitQ0 [$];
  logic bitQ1 [$];
  int   doneQ0 [$];
  int   doneQ1 [$];

  piso_tx_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .i_clk(clk), .i_rst(rst), .i_din(din[0]), .i_din_valid(dinValid[0]),
    .o_din_ready(dinReady[0]), .o_sout(sout[0]), .o_sout_valid(soutValid[0]),
    .i_sout_ready(soutReady[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  piso_tx_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .i_clk(clk), .i_rst(rst), .i_din(din[1]), .i_din_valid(dinValid[1]),
    .o_din_ready(dinReady[1]), .o_sout(sout[1]), .o_sout_valid(soutValid[1]),
    .i_sout_ready(soutReady[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: each accepted serial beat and each done pulse is matched to the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (soutValid[0] && soutReady[0]) begin
        if (bitQ0.size() == 0) checkOutput("msbExtraBit", 32'd1, 32'd0);
        else checkOutput("msbBit", 32'(sout[0]), 32'(bitQ0.pop_front()));
      end
      if (done[0]) begin
        if (doneQ0.size() == 0) checkOutput("msbUnexpectedDone", 32'd1, 32'd0);
        else checkOutput("msbDoneCycle", 32'(cyc), 32'(doneQ0.pop_front()));
      end
      if (soutValid[1] && soutReady[1]) begin
        if (bitQ1.size() == 0) checkOutput("lsbExtraBit", 32'd1, 32'd0);
        else checkOutput("lsbBit", 32'(sout[1]), 32'(bitQ1.pop_front()));
      end
      if (done[1]) begin
        if (doneQ1.size() == 0) checkOutput("lsbUnexpectedDone", 32'd1, 32'd0);
        else checkOutput("lsbDoneCycle", 32'(cyc), 32'(doneQ1.pop_front()));
      end
    end
  end

  // expBits holds the hand-computed serial sequence, first-transmitted bit in [7].
  task automatic applyStimulus(input int sel, input logic [7:0] word,
                               input logic [7:0] expBits, input int stallLen);
    int k;
    k = cyc;
    for (int i = 7; i >= 0; i--) begin
      if (sel == 0) bitQ0.push_back(expBits[i]);
      else bitQ1.push_back(expBits[i]);
    end
    if (sel == 0) doneQ0.push_back(k + 9 + stallLen);
    else doneQ1.push_back(k + 9 + stallLen);
    din[sel] = word;
    dinValid[sel] = 1'b1;
    soutReady[sel] = 1'b1;
    tick();
    dinValid[sel] = 1'b0;
    din[sel] = 8'h5A;
    if (stallLen > 0) begin
      tick();
      soutReady[sel] = 1'b0;
      for (int s = 0; s < stallLen; s++) begin
        @(negedge clk);
        checkOutput("stallSout", 32'(sout[sel]), 32'(expBits[6]));
        checkOutput("stallValid", 32'(soutValid[sel]), 32'd1);
        tick();
      end
      soutReady[sel] = 1'b1;
    end
    while (cyc < k + 9 + stallLen) tick();
    @(negedge clk);
    checkOutput("busyAfterWord", 32'(busy[sel]), 32'd0);
    checkOutput("readyAfterWord", 32'(dinReady[sel]), 32'd1);
    tick();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      din[s] = 8'h00;
      dinValid[s] = 1'b0;
      soutReady[s] = 1'b1;
    end
    tick();
    tick();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("resetOutputs",
                  32'({sout[s], soutValid[s], busy[s], done[s], dinReady[s]}), 32'b00001);
    end
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("idleOutputs",
                  32'({soutValid[0], busy[0], done[0], dinReady[0]}), 32'b0001);
    end
    tick();

    applyStimulus(0, 8'hA5, 8'b1010_0101, 0);
    applyStimulus(1, 8'hA5, 8'b1010_0101, 0);
    applyStimulus(1, 8'h01, 8'b1000_0000, 0);
    applyStimulus(0, 8'hC3, 8'b1100_0011, 3);

    // Back-to-back: FF then 00 with din_valid held across the boundary.
    k = cyc;
    for (int i = 0; i < 8; i++) bitQ0.push_back(1'b1);
    for (int i = 0; i < 8; i++) bitQ0.push_back(1'b0);
    doneQ0.push_back(k + 9);
    doneQ0.push_back(k + 17);
    din[0] = 8'hFF;
    dinValid[0] = 1'b1;
    soutReady[0] = 1'b1;
    tick();
    din[0] = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput("b2bDinReady", 32'(dinReady[0]), (c == 8) ? 32'd1 : 32'd0);
      checkOutput("b2bValid", 32'(soutValid[0]), 32'd1);
      tick();
    end
    dinValid[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("b2bValid2", 32'(soutValid[0]), 32'd1);
      tick();
    end
    while (cyc < k + 19) tick();

    // Reset after three bits of A5: word discarded, no done pulse.
    k = cyc;
    for (int i = 7; i >= 0; i--) bitQ0.push_back(1'(8'hA5 >> i));
    din[0] = 8'hA5;
    dinValid[0] = 1'b1;
    tick();
    dinValid[0] = 1'b0;
    tick();
    tick();
    tick();
    soutReady[0] = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("midResetOutputs",
                32'({soutValid[0], busy[0], dinReady[0], done[0]}), 32'b0010);
    checkOutput("midResetBitsLeft", 32'(bitQ0.size()), 32'd5);
    bitQ0.delete();
    rst = 1'b0;
    soutReady[0] = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    applyStimulus(0, 8'h3C, 8'b0011_1100, 0);

    for (int c = 0; c < 4; c++) tick();
    checkOutput("msbBitsPending", 32'(bitQ0.size()), 32'd0);
    checkOutput("lsbBitsPending", 32'(bitQ1.size()), 32'd0);
    checkOutput("msbDonePending", 32'(doneQ0.size()), 32'd0);
    checkOutput("lsbDonePending", 32'(doneQ1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
